// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: registered multi-lane instruction decode stage.
//
// Each lane word is split into opcode[31:26], dst[25:21], src0[20:16], src1[15:11] and an
// 11-bit immediate sign-extended to DATA_W. Opcodes >= NUM_OPS on active lanes are flagged
// illegal. Decoding happens before the output register, so both the main and skid
// registers hold decoded bundles. A 2-entry skid buffer keeps full throughput while
// in_ready_o is a flop.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   in_valid_i / in_ready_o        input handshake
//   in_instr_i, in_mask_i          raw words per lane, lane-active mask
//   out_valid_o / out_ready_i      output handshake
//   out_opcode_o .. out_imm_o      decoded fields per lane (zero on masked-off lanes)
//   out_mask_o, out_illegal_o      registered mask, per-lane illegal flags
//   illegal_any_o                  OR of out_illegal_o, qualified by out_valid_o
//   perf_bundles_o, perf_illegal_o accepted-bundle / consumed-illegal-lane counters
//                                  (present only when DECODE_PERF_EN is defined)
module decode_stage_pipe #(
  parameter int unsigned LANES   = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_OPS = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [LANES-1:0][31:0]        in_instr_i,
  input  logic [LANES-1:0]              in_mask_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [LANES-1:0][5:0]         out_opcode_o,
  output logic [LANES-1:0][4:0]         out_dst_o,
  output logic [LANES-1:0][4:0]         out_src0_o,
  output logic [LANES-1:0][4:0]         out_src1_o,
  output logic [LANES-1:0][DATA_W-1:0]  out_imm_o,
  output logic [LANES-1:0]              out_mask_o,
  output logic [LANES-1:0]              out_illegal_o,
`ifdef DECODE_PERF_EN
  output logic [31:0]                   perf_bundles_o,
  output logic [31:0]                   perf_illegal_o,
`endif
  output logic                          illegal_any_o
);

  typedef struct packed {
    logic [5:0]        opcode;
    logic [4:0]        dst;
    logic [4:0]        src0;
    logic [4:0]        src1;
    logic [DATA_W-1:0] imm;
    logic              illegal;
  } lane_t;

  typedef struct packed {
    lane_t [LANES-1:0] lane;
    logic [LANES-1:0]  mask;
  } bundle_t;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e  state_q, state_d;
  bundle_t dec;
  bundle_t main_q, main_d;
  bundle_t skid_q, skid_d;
  logic    in_ready_q, valid_q, illegal_any_q, illegal_any_d;
  logic    accept, consume;

  // Decode ahead of the register; masked-off lanes decode to all zeros.
  always_comb begin
    dec = '0;
    for (int l = 0; l < LANES; l++) begin
      dec.mask[l] = in_mask_i[l];
      if (in_mask_i[l]) begin
        dec.lane[l].opcode  = in_instr_i[l][31:26];
        dec.lane[l].dst     = in_instr_i[l][25:21];
        dec.lane[l].src0    = in_instr_i[l][20:16];
        dec.lane[l].src1    = in_instr_i[l][15:11];
        dec.lane[l].imm     = {{(DATA_W-11){in_instr_i[l][10]}}, in_instr_i[l][10:0]};
        dec.lane[l].illegal = 32'(in_instr_i[l][31:26]) >= NUM_OPS;
      end
    end
  end

  assign accept  = in_valid_i && in_ready_q;
  assign consume = valid_q && out_ready_i;

  always_comb begin
    state_d       = state_q;
    main_d        = main_q;
    skid_d        = skid_q;
    illegal_any_d = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          main_d  = dec;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && !consume) begin
          skid_d  = dec;
          state_d = StFull;
        end else if (accept && consume) begin
          main_d  = dec;
        end else if (consume) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        // in_ready is low here, so only a consume can happen.
        if (consume) begin
          main_d  = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    if (state_d != StEmpty) begin
      for (int l = 0; l < LANES; l++) begin
        illegal_any_d = illegal_any_d | main_d.lane[l].illegal;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StEmpty;
      main_q        <= '0;
      skid_q        <= '0;
      in_ready_q    <= 1'b1;
      valid_q       <= 1'b0;
      illegal_any_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      main_q        <= main_d;
      skid_q        <= skid_d;
      in_ready_q    <= (state_d != StFull);
      valid_q       <= (state_d != StEmpty);
      illegal_any_q <= illegal_any_d;
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      out_opcode_o[l]  = main_q.lane[l].opcode;
      out_dst_o[l]     = main_q.lane[l].dst;
      out_src0_o[l]    = main_q.lane[l].src0;
      out_src1_o[l]    = main_q.lane[l].src1;
      out_imm_o[l]     = main_q.lane[l].imm;
      out_illegal_o[l] = main_q.lane[l].illegal;
    end
  end

  assign out_mask_o    = main_q.mask;
  assign out_valid_o   = valid_q;
  assign in_ready_o    = in_ready_q;
  assign illegal_any_o = illegal_any_q;

`ifdef DECODE_PERF_EN
  logic [31:0] perf_bundles_q, perf_bundles_d;
  logic [31:0] perf_illegal_q, perf_illegal_d;
  logic [31:0] illegal_cnt;

  always_comb begin
    illegal_cnt = '0;
    for (int l = 0; l < LANES; l++) begin
      illegal_cnt = illegal_cnt + 32'(main_q.lane[l].illegal);
    end
    perf_bundles_d = perf_bundles_q + (accept ? 32'd1 : 32'd0);
    perf_illegal_d = perf_illegal_q + (consume ? illegal_cnt : 32'd0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_bundles_q <= '0;
      perf_illegal_q <= '0;
    end else begin
      perf_bundles_q <= perf_bundles_d;
      perf_illegal_q <= perf_illegal_d;
    end
  end

  assign perf_bundles_o = perf_bundles_q;
  assign perf_illegal_o = perf_illegal_q;
`endif

endmodule

// File: tb/tb_decode_stage_pipe.sv
module tb_decode_stage_pipe;
  localparam int LANES  = 4;
  localparam int DATA_W = 32;

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b0;
  logic                         in_valid = 1'b0;
  logic                         in_ready;
  logic [LANES-1:0][31:0]       in_instr = '0;
  logic [LANES-1:0]             in_mask = '0;
  logic                         out_valid;
  logic                         out_ready = 1'b0;
  logic [LANES-1:0][5:0]        out_opcode;
  logic [LANES-1:0][4:0]        out_dst, out_src0, out_src1;
  logic [LANES-1:0][DATA_W-1:0] out_imm;
  logic [LANES-1:0]             out_mask, out_illegal;
  logic                         illegal_any;
`ifdef DECODE_PERF_EN
  logic [31:0]                  perf_bundles, perf_illegal;
`endif

  decode_stage_pipe dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_instr_i    (in_instr),
    .in_mask_i     (in_mask),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_opcode_o  (out_opcode),
    .out_dst_o     (out_dst),
    .out_src0_o    (out_src0),
    .out_src1_o    (out_src1),
    .out_imm_o     (out_imm),
    .out_mask_o    (out_mask),
    .out_illegal_o (out_illegal),
`ifdef DECODE_PERF_EN
    .perf_bundles_o(perf_bundles),
    .perf_illegal_o(perf_illegal),
`endif
    .illegal_any_o (illegal_any)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LANES-1:0][31:0] instr;
    logic [LANES-1:0]       mask;
    int                     cyc;
    bit                     lat;
  } item_t;

  item_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference decode: f selects 0 opcode, 1 dst, 2 src0, 3 src1, 4 imm, 5 mask, 6 illegal, 7 any.
  function automatic logic [255:0] model(input item_t it, input int f);
    logic [255:0] r;
    logic [31:0]  w;
    logic         m, ill;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      w   = it.instr[l];
      m   = it.mask[l];
      ill = m && (w[31:26] >= 6'd32);
      case (f)
        0: if (m) r[l*6 +: 6] = w[31:26];
        1: if (m) r[l*5 +: 5] = w[25:21];
        2: if (m) r[l*5 +: 5] = w[20:16];
        3: if (m) r[l*5 +: 5] = w[15:11];
        4: if (m) r[l*32 +: 32] = {{21{w[10]}}, w[10:0]};
        5: r[l] = m;
        6: r[l] = ill;
        default: r[0] = r[0] | ill;
      endcase
    end
    return r;
  endfunction

  // Monitor: samples just after the falling edge, pops the scoreboard on each consumed bundle.
  logic [255:0] snap, prev_snap;
  bit prev_stall = 0;
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        prev_stall = 0;
        continue;
      end
      snap = {out_valid, illegal_any, out_illegal, out_mask, out_imm, out_src1, out_src0,
              out_dst, out_opcode};
      if (prev_stall) chk("stall_stable", snap, prev_snap);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", out_valid, 0);
        end else begin
          it = q.pop_front();
          chk("opcode", 256'(out_opcode), model(it, 0));
          chk("dst", 256'(out_dst), model(it, 1));
          chk("src0", 256'(out_src0), model(it, 2));
          chk("src1", 256'(out_src1), model(it, 3));
          chk("imm", 256'(out_imm), model(it, 4));
          chk("mask", 256'(out_mask), model(it, 5));
          chk("illegal", 256'(out_illegal), model(it, 6));
          chk("illegal_any", 256'(illegal_any), model(it, 7));
          if (it.lat) chk("latency", cyc, it.cyc + 1);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_snap  = snap;
    end
  end

  task automatic send(input logic [LANES-1:0][31:0] ins, input logic [LANES-1:0] m,
                      input bit lat, input bit need_rdy);
    item_t it;
    bit    rdy;
    int    n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = ins;
    in_mask  = m;
    forever begin
      rdy    = in_ready;
      it.cyc = cyc;
      if (need_rdy) chk("stream_in_ready", in_ready, 1);
      @(posedge clk);
      if (rdy) break;
      n++;
      if (n > 50) begin
        chk("send_timeout", in_ready, 1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    it.instr = ins;
    it.mask  = m;
    it.lat   = lat;
    q.push_back(it);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LANES-1:0][31:0] a, b, c, w;
    logic [LANES-1:0]       m;

    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_any", illegal_any, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Basic decode, lanes 1..3 masked off with garbage words
    w = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0C22_1FFF};
    send(w, 4'b0001, 1, 0);
    #1;
    chk("basic_valid", out_valid, 1);
    chk("basic_opcode0", out_opcode[0], 6'd3);
    chk("basic_dst0", out_dst[0], 5'd1);
    chk("basic_src0_0", out_src0[0], 5'd2);
    chk("basic_src1_0", out_src1[0], 5'd3);
    chk("basic_imm0", out_imm[0], 32'hFFFF_FFFF);
    chk("basic_upper_lanes", {out_opcode[3:1], out_imm[3:1], out_dst[3:1]}, 0);
    chk("basic_any", illegal_any, 0);
    idle();

    // Illegal opcode 63, active then masked off
    w = {32'h0, 32'h0, 32'h0, 32'hFC00_0000};
    send(w, 4'b0001, 1, 0);
    #1;
    chk("ill_lane0", out_illegal, 4'b0001);
    chk("ill_any", illegal_any, 1);
    send(w, 4'b0000, 1, 0);
    #1;
    chk("ill_masked", out_illegal, 4'b0000);
    chk("ill_masked_opcode", out_opcode, 0);
    chk("ill_masked_any", illegal_any, 0);
    idle();
    drain();

    // Backpressure: A and B fill the stage, C waits until out_ready rises
    out_ready = 1'b0;
    a = {32'h1111_0400, 32'h7C00_0001, 32'h8000_07FF, 32'h0421_8C05};
    b = {32'h2468_ACE0, 32'h13579BDF, 32'hF000_0400, 32'h0000_03FF};
    c = {32'h7FFF_FFFF, 32'hDEAD_BEEF, 32'h0C22_1FFF, 32'h5555_AAAA};
    send(a, 4'b1111, 0, 0);
    send(b, 4'b1011, 0, 0);
    fork
      send(c, 4'b0110, 0, 0);
      begin
        repeat (3) begin
          @(negedge clk);
          #1;
          chk("bp_in_ready_low", in_ready, 0);
          chk("bp_out_valid", out_valid, 1);
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    idle();
    drain();

    // Streaming at full rate, latency 1, in_ready never drops
    for (int i = 0; i < 100; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      m = 4'($urandom);
      send(w, m, 1, 1);
    end
    idle();
    drain();

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    send(a, 4'b1111, 0, 0);
    send(b, 4'b1111, 0, 0);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_fields", {out_opcode, out_dst, out_src0, out_src1, out_mask, out_illegal}, 0);
    chk("arst_imm", 256'(out_imm), 0);
    chk("arst_any", illegal_any, 0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("arst_no_stale", out_valid, 0);

    // Ten bundles with three illegal active lanes; opcode 31 is legal, 32 is illegal
    for (int i = 0; i < 10; i++) begin
      w = {32'h7C00_0000, 32'h0400_0000, 32'h0400_0000, 32'h0400_0000};
      m = 4'b1111;
      if (i == 2) w[1] = 32'hFC00_0000;
      if (i == 5) begin
        w[0] = 32'h8000_0000;
        w[3] = 32'h8000_0000;
      end
      if (i == 7) begin
        w[2] = 32'hFC00_0000;
        m    = 4'b1011;
      end
      send(w, m, 1, 0);
    end
    idle();
    drain();
`ifdef DECODE_PERF_EN
    @(negedge clk);
    chk("perf_bundles", perf_bundles, 32'd10);
    chk("perf_illegal", perf_illegal, 32'd3);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
